// File: rtl/sar_search_if.sv
// Purpose: bundles the sar_search control/result signals and the comparator flag return path.
// Latency: none (wires only); the controller registers everything it drives.
// Backpressure: none; start is a level request, done is a single-cycle pulse.
// Ports/modports:
//   master - the search controller: drives guess/busy/done/result/found, receives start and flags.
//   slave  - the requester + comparator side: drives start/less/greater/equal, observes the rest.
interface sar_search_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             less;
  logic             greater;
  logic             equal;
  logic [WIDTH-1:0] guess;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             found;

  modport master (
    input  start, less, greater, equal,
    output guess, busy, done, result, found
  );

  modport slave (
    output start, less, greater, equal,
    input  guess, busy, done, result, found
  );
endinterface

// File: rtl/sar_search.sv
// Purpose: successive-approximation search that drives a comparator operand and converges MSB first.
// Latency: done 1..WIDTH+1 cycles after start is sampled (early exit on equal, else via VERIFY).
// Backpressure: start is ignored while busy; no stall input, the comparator answers every cycle.
// Ports: clk, rst_n (async active-low); bus (sar_search_if.master) carries start, flags
//        less/greater/equal in, and guess, busy, done, result, found out.
module sar_search #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  sar_search_if.master bus
);

  localparam int KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_TRY    = 2'd1,
    S_VERIFY = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [KW-1:0]    k_q,      k_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             found_q,  found_d;

  logic [WIDTH-1:0] trial_bit;
  logic [WIDTH-1:0] guess;

  // guess depends only on registered state, so the comparator loop is
  // broken at the flops and the flags are purely a same-cycle return path.
  always_comb begin
    trial_bit = {{(WIDTH-1){1'b0}}, 1'b1} << k_q;
    guess     = '0;
    case (state_q)
      S_TRY:    guess = acc_q | trial_bit;
      S_VERIFY: guess = acc_q;
      default:  guess = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    k_d      = k_q;
    done_d   = 1'b0;
    result_d = result_q;
    found_d  = found_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d   = '0;
          k_d     = KW'(WIDTH - 1);
          state_d = S_TRY;
        end
      end
      S_TRY: begin
        if (bus.equal) begin
          result_d = guess;
          found_d  = 1'b1;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          // No flag at all is treated like "less": keep the trial bit.
          if (!bus.greater) begin
            acc_d = guess;
          end
          if (k_q == '0) begin
            state_d = S_VERIFY;
          end else begin
            k_d = k_q - KW'(1);
          end
        end
      end
      S_VERIFY: begin
        // Only reachable for target 0 or a misbehaving comparator.
        result_d = acc_q;
        found_d  = bus.equal;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      k_q      <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      found_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      k_q      <= k_d;
      done_q   <= done_d;
      result_q <= result_d;
      found_q  <= found_d;
    end
  end

  assign bus.guess  = guess;
  assign bus.busy   = (state_q != S_IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.found  = found_q;

endmodule

// File: tb/tb_sar_search.sv
// Purpose: randomized/directed scoreboard bench for sar_search against a behavioural comparator.
// Latency: expected done latency, result, found and guess sequence come from a closed-form model.
// Backpressure: none; new starts are raised during the done cycle (back-to-back).
module tb_sar_search;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] target;
  logic         eq_broken;

  sar_search_if #(.WIDTH(W)) bus ();

  sar_search #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // Behavioural 4-bit magnitude comparator; eq_broken models a stuck-at-0 equal flag.
  assign bus.equal   = !eq_broken && (bus.guess == target);
  assign bus.greater = (bus.guess > target);
  assign bus.less    = (bus.guess < target);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int tgt;
    bit broken;
    int result;
    bit found;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ctz(input int v);
    int n = 0;
    while (((v >> n) & 1) == 0 && n < W) n++;
    return n;
  endfunction

  // Result model: a correct comparator always finds the target; the only
  // early-exit timing depends on where the lowest set bit of the target is.
  function automatic exp_t model(input int t, input bit broken);
    exp_t e;
    e.tgt    = t;
    e.broken = broken;
    e.result = t;
    e.found  = !broken;
    if (broken || t == 0) e.lat = W + 1;
    else                  e.lat = W - ctz(t);
    return e;
  endfunction

  // Trial b presents the target's bits above b with bit b set; a search that
  // never sees equal finishes with a VERIFY presenting the target itself.
  function automatic void model_guesses(input exp_t e, output int seq[$]);
    int g;
    bit hit = 1'b0;
    seq = {};
    for (int b = W - 1; b >= 0; b--) begin
      g = ((e.tgt >> (b + 1)) << (b + 1)) | (1 << b);
      seq.push_back(g);
      if (g == e.tgt && !e.broken) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) seq.push_back(e.tgt);
  endfunction

  // Monitor: records every busy cycle's guess and checks each done pulse.
  int busy_cnt = 0;
  int gq[$];

  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_n) begin
        busy_cnt = 0;
        gq = {};
      end else begin
        if (bus.busy) begin
          busy_cnt++;
          gq.push_back(int'(bus.guess));
        end
        if (bus.done) begin
          exp_t e;
          int   seq[$];
          int   bad;
          chk("busy_low_at_done", int'(bus.busy), 0);
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            model_guesses(e, seq);
            chk($sformatf("result_t%0d", e.tgt), int'(bus.result), e.result);
            chk($sformatf("found_t%0d", e.tgt), int'(bus.found), int'(e.found));
            chk($sformatf("latency_t%0d", e.tgt), busy_cnt, e.lat);
            bad = (gq.size() != seq.size()) ? 1 : 0;
            for (int i = 0; i < gq.size() && i < seq.size(); i++)
              if (gq[i] != seq[i]) bad = 1;
            chk($sformatf("guess_seq_t%0d_len%0d", e.tgt, gq.size()), bad, 0);
          end
          busy_cnt = 0;
          gq = {};
        end
      end
    end
  end

  // Stimulus: starts are raised at a negedge and held for one sampling edge.
  task automatic issue(input int t, input bit broken);
    target    = W'(t);
    eq_broken = broken;
    bus.start = 1'b1;
    exp_q.push_back(model(t, broken));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("done_timeout", 0, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    target    = '0;
    eq_broken = 1'b0;
    #2;
    chk("rst_guess",  int'(bus.guess),  0);
    chk("rst_busy",   int'(bus.busy),   0);
    chk("rst_done",   int'(bus.done),   0);
    chk("rst_result", int'(bus.result), 0);
    chk("rst_found",  int'(bus.found),  0);
    @(negedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Directed cases, each next start raised in the previous done cycle.
    issue(5, 0);  wait_done();
    issue(8, 0);  wait_done();
    issue(0, 0);  wait_done();
    issue(15, 0); wait_done();

    // Full sweep, back-to-back.
    for (int t = 0; t < 16; t++) begin
      issue(t, 0);
      wait_done();
    end

    // start pulsed mid-search must not restart the search.
    issue(0, 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    // Stuck-at-0 equal flag: target 0 then a few random targets.
    issue(0, 1); wait_done();
    for (int i = 0; i < 3; i++) begin
      issue(int'($urandom_range(0, 15)), 1);
      wait_done();
    end

    // Random targets with a healthy comparator.
    for (int i = 0; i < 20; i++) begin
      issue(int'($urandom_range(0, 15)), 0);
      wait_done();
    end

    // Reset in the third TRY cycle of a search that would run to VERIFY.
    issue(9, 0); wait_done();
    issue(0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_abort_guess", int'(bus.guess), 2);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    chk("abort_guess",  int'(bus.guess),  0);
    chk("abort_busy",   int'(bus.busy),   0);
    chk("abort_done",   int'(bus.done),   0);
    chk("abort_result", int'(bus.result), 0);
    chk("abort_found",  int'(bus.found),  0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    issue(6, 0);
    wait_done();

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sar_search.md
# sar_search

Successive-approximation search controller that acts as the initiator for the team's 4-bit magnitude comparator. It drives a trial value onto the comparator's `a` operand and reads back the `less`/`greater`/`equal` flags, while an unknown target sits on the comparator's `b` operand. It converges on the target one bit per cycle, MSB first, and reports the result with a one-cycle `done` pulse. It also serves as a bench driver and as a building block for threshold-search and ADC-style loops.

## Interface
- `WIDTH`, default 4: operand width. Must match the comparator width; legal range ≥ 1.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request a search; sampled only in IDLE.
- `less`  input  1  comparator flag: guess < target.
- `greater`  input  1  comparator flag: guess > target.
- `equal`  input  1  comparator flag: guess == target.
- `guess`  output  WIDTH  trial value driven to comparator operand `a`.
- `busy`  output  1  high in TRY and VERIFY.
- `done`  output  1  one-cycle pulse when a search completes.
- `result`  output  WIDTH  final value; held until the next accepted start.
- `found`  output  1  1 if the final value was confirmed equal; held with `result`.

## Operation
- Internal state: `acc` (WIDTH bits), bit index `k` (⌈log2 WIDTH⌉ bits, minimum 1), FSM state.
- States:
  - IDLE: `guess = 0`. On `start`, set `acc = 0` and `k = WIDTH-1`, then go to TRY.
  - TRY: `guess = acc | (1<<k)`. The flags are evaluated at the clock edge with priority equal > greater > less. If none of the three flags is set, it is treated as less.
    - equal: `result = guess`, `found = 1`, pulse `done`, go to IDLE.
    - greater: `acc` unchanged (trial bit rejected).
    - less: `acc = guess` (trial bit kept).
    - After the greater/less update: if `k == 0`, go to VERIFY; otherwise `k = k-1` and stay in TRY.
  - VERIFY: `guess = acc`. At the edge, `result = acc`, `found = equal`, pulse `done`, go to IDLE.
- `guess` is decoded from registered state only. There is no combinational path from the flags to `guess`, so no loop through the comparator.
- With a consistent comparator, VERIFY is reached only for target 0, and `found` is always 1.
- With a broken or inconsistent comparator, VERIFY can end with `found = 0`. `result` still holds the best `acc`.
- `start` while busy is ignored. `start` in the same cycle that `done` is high is accepted, because the FSM is in IDLE in that cycle.

## Timing
- Reset values: `guess = 0`, `busy = 0`, `done = 0`, `result = 0`, `found = 0`. State is IDLE, `acc = 0`, `k = 0`.
- Assertion of `rst_n` at any point, including mid-search, returns the block to IDLE asynchronously with all outputs at their reset values. No `done` is produced for the aborted search.
- Let edge 0 be the edge at which `start` is sampled high in IDLE. TRY occupies the cycles after edges 0 … m-1.
  - Exit on equal at the m-th trial: `done` is high during the cycle after edge m.
  - Exit via VERIFY (all WIDTH trials rejected or kept without equal): `done` is high during the cycle after edge WIDTH+1.
- Bounds: minimum latency is 1 (target = 2^(WIDTH-1)); maximum is WIDTH+1.
- `busy` is high from the cycle after edge 0 through the last TRY or VERIFY cycle. It is low in the same cycle that `done` is high.
- `result` and `found` update at the same edge that raises `done`.
- Flags must be stable at the sampling edge. The comparator is combinational, so flag settling is a same-cycle path from `guess` through the comparator and back.

## Test plan
- Bench: instantiate the comparator with `a = guess` and `b = target` register, `WIDTH = 4`.
- Target 5: guesses 8, 4, 6, 5 on successive cycles → `done` after edge 4, `result = 5`, `found = 1`.
- Target 8 → single TRY with guess 8, `done` after edge 1, `result = 8`.
- Target 0: guesses 8, 4, 2, 1, then VERIFY with guess 0 → `done` after edge 5, `result = 0`, `found = 1`.
- Target 15: guesses 8, 12, 14, 15 → `done` after edge 4, `result = 15`.
- Sweep all targets 0–15, with back-to-back `start` (raised during the `done` cycle) → every `result == target`, `found = 1`, latency ≤ 5. A `start` pulsed mid-search is ignored.
- Fault cases:
  - `equal` forced to 0, target 0 → VERIFY gives `found = 0`, `result = 0`.
  - `rst_n` pulsed low at the third TRY → outputs return to 0 immediately, no `done` pulse, and the next `start` searches normally.
